key_debounce_array: RTL and testbench
=====================================

Name: key_debounce_array

Overview:
- Multi-channel, parametrised successor to the single-key bounce eliminator.
- Each channel is synchronised, then debounced against a shared slow tick. Each channel produces a clean level plus press/release pulses.
- Press events are queued per channel and presented one at a time on a valid/ack handshake, with the channel index as key code.
- Sits between raw keypad/button pins and the interface FSM that consumes key codes.

Parameters:
- N_CH, 4, number of independent key channels (1..32)
- TICK_DIV, 54000, clk cycles per debounce sample tick (>=2)
- STABLE_TICKS, 3, consecutive ticks a new value must persist before the level changes (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- REPEAT_DELAY, 20, ticks held before the first auto-repeat (only with KDA_AUTO_REPEAT_EN)
- REPEAT_RATE, 5, ticks between subsequent repeats (only with KDA_AUTO_REPEAT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- key_in  in  N_CH  raw asynchronous key inputs, 1 = pressed
- key_level  out  N_CH  debounced level per channel
- press_pulse  out  N_CH  1-clk pulse on debounced rising edge
- release_pulse  out  N_CH  1-clk pulse on debounced falling edge
- data_valid  out  1  key_code holds a queued press event
- key_code  out  $clog2(N_CH) (min 1)  index of the presented channel
- ack  in  1  consumer accepts the presented event
- overrun  out  1  sticky: a press arrived while the same channel's event was still pending

Behaviour:
- Reset values: all outputs 0; tick counter 0; all synchroniser, stable-counter, pending and state registers 0; FSM in IDLE. Reset asserted mid-operation discards pending events and any presented event immediately.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly one clk when counter == TICK_DIV-1.
  - Counter width is $clog2(TICK_DIV).
- Channel datapath:
  - key_in passes through SYNC_STAGES flops to give s.
  - Channel state is evaluated only on tick cycles; s between ticks is ignored.
  - On tick with s != key_level: cnt increments. When cnt reaches STABLE_TICKS-1 on that tick, key_level toggles and cnt clears.
  - On tick with s == key_level: cnt clears.
  - press_pulse / release_pulse assert in the same clk that key_level changes, registered, and last exactly 1 clk.
  - Worst-case latency from a stable key_in edge to key_level change: SYNC_STAGES + STABLE_TICKS*TICK_DIV clk.
- Pending queue:
  - pending[i] is set by press_pulse[i].
  - If pending[i] is already 1 when press_pulse[i] fires, the event coalesces and overrun is set. overrun clears only on rst.
- Handshake FSM, states IDLE and VALID:
  - IDLE: if any pending bit is set, select the lowest index. On the next edge: key_code <= idx, data_valid <= 1, pending[idx] cleared, go to VALID.
  - Same-cycle set and clear of one pending bit: set wins.
  - VALID: key_code and data_valid stay stable until ack. When ack = 1, data_valid <= 0 on the next edge and the FSM goes to IDLE.
  - ack in IDLE is ignored.
  - The next event is presented no earlier than 1 clk after returning to IDLE, so back-to-back events have 1 idle cycle between them.
  - A press on the channel currently presented in VALID sets its pending bit again and is delivered later as a new event.
- Release events are not queued; they are only visible as release_pulse.

Optional Feature:
- Macro: KDA_AUTO_REPEAT_EN.
- Defined:
  - Each channel has a repeat counter.
  - While key_level = 1, after REPEAT_DELAY ticks the channel generates a queued event, i.e. it sets pending as if pressed. After that it repeats every REPEAT_RATE ticks.
  - The counter resets when key_level falls.
  - Repeat events do not pulse press_pulse.
  - Overrun rules apply to repeat events as well.
- Undefined: no repeat logic; REPEAT_* parameters are unused.

Decomposition:
- Package kda_pkg holds:
  - the FSM state enum typedef (KDA_IDLE, KDA_VALID)
  - default constants for TICK_DIV, STABLE_TICKS and SYNC_STAGES
  - a function returning the lowest set bit index
- Sub-module kda_channel contains the synchroniser, stable counter, level register, edge pulses and optional repeat counter. It is instantiated N_CH times in a generate loop.
- The tick generator, pending register and FSM live in the top module.

Test Plan (sim with TICK_DIV=4, STABLE_TICKS=3, N_CH=4):
- Clean press on ch2 held 40 clk -> key_level[2] rises within SYNC_STAGES+12 clk. press_pulse[2] lasts 1 clk. data_valid=1 with key_code=2 one clk later.
- ch1 bouncing 0/1 every 3 clk for 30 clk, then stable 1 -> no key_level change during bouncing; exactly one press_pulse after it settles.
- ch3 and ch0 pressed on the same tick, ack held 1 -> key_code 0 presented first, then 3. Exactly 1 idle clk between the two events.
- ch1 pressed, released, pressed again with ack=0 throughout -> one event presented; pending[1] set again; overrun=1 only if a third press arrives before the first ack.
- rst asserted while data_valid=1 and pending is non-empty -> all outputs are 0 asynchronously; no event is presented after rst deasserts unless keys are pressed again.
- With KDA_AUTO_REPEAT_EN, REPEAT_DELAY=2, REPEAT_RATE=1, ack tied 1, ch0 held 40 clk -> events for ch0 at the initial press, then every 4 clk starting 8 clk later.

Source files
------------

// File: rtl/kda_pkg.sv
// Shared types and defaults for the key_debounce_array block: handshake FSM
// state encoding, default timing constants and a lowest-set-bit helper.
package kda_pkg;

  typedef enum logic {
    KDA_IDLE  = 1'b0,
    KDA_VALID = 1'b1
  } kda_state_e;

  localparam int KDA_TICK_DIV_DEF     = 54000;
  localparam int KDA_STABLE_TICKS_DEF = 3;
  localparam int KDA_SYNC_STAGES_DEF  = 2;

  // Index of the lowest set bit; 0 when the vector is empty (callers gate on |vec).
  function automatic logic [4:0] kda_lowest_set(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kda_channel.sv
// One debounce channel: input synchroniser, stable-tick counter, debounced
// level with registered press/release pulses. With KDA_AUTO_REPEAT_EN defined
// it also carries a repeat down-counter that raises repeat_evt_o while held.
module kda_channel
  import kda_pkg::*;
#(
  parameter int STABLE_TICKS = KDA_STABLE_TICKS_DEF,
  parameter int SYNC_STAGES  = KDA_SYNC_STAGES_DEF
`ifdef KDA_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic press_evt_o,
  output logic repeat_evt_o
);

  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, release_q;
  logic                   sync_s, toggle, press_evt, release_evt;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Count consecutive ticks disagreeing with the level; flip on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    toggle  = 1'b0;
    if (tick_i) begin
      if (sync_s != level_q) begin
        if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
          toggle  = 1'b1;
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign press_evt   = toggle & ~level_q;
  assign release_evt = toggle & level_q;

  // Synchroniser shift, counter, level and one-clk edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], key_i};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_evt;
      release_q <= release_evt;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign press_evt_o = press_evt;

`ifdef KDA_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_evt;

  // Load the delay on press, fire at count 1 and reload with the rate.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_evt   = 1'b0;
    if (press_evt) begin
      rep_cnt_d = REP_W'(REPEAT_DELAY);
    end else if (release_evt) begin
      rep_cnt_d = '0;
    end else if (tick_i && level_q) begin
      if (rep_cnt_q == REP_W'(1)) begin
        rep_evt   = 1'b1;
        rep_cnt_d = REP_W'(REPEAT_RATE);
      end else begin
        rep_cnt_d = rep_cnt_q - 1'b1;
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end

  assign repeat_evt_o = rep_evt;
`else
  assign repeat_evt_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// N_CH-channel key debouncer with per-channel press queue and valid/ack
// key-code handshake. Holds the shared tick divider, pending bits and the
// presentation FSM. Optional auto-repeat: define KDA_AUTO_REPEAT_EN.
//
//   state     | meaning
//   KDA_IDLE  | nothing presented; picks lowest pending channel next edge
//   KDA_VALID | key_code presented, data_valid high until ack
module key_debounce_array
  import kda_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = KDA_TICK_DIV_DEF,
  parameter int STABLE_TICKS = KDA_STABLE_TICKS_DEF,
  parameter int SYNC_STAGES  = KDA_SYNC_STAGES_DEF,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_CH-1:0]                              key_in,
  output logic [N_CH-1:0]                              key_level,
  output logic [N_CH-1:0]                              press_pulse,
  output logic [N_CH-1:0]                              release_pulse,
  output logic                                         data_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   key_code,
  input  logic                                         ack,
  output logic                                         overrun
);

  localparam int KCW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW  = $clog2(TICK_DIV);

  logic [TW-1:0]   tick_cnt_q;
  logic            tick;
  logic [N_CH-1:0] press_evt, repeat_evt, set_vec, clr_vec;
  logic [N_CH-1:0] pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic [KCW-1:0]  key_code_q, key_code_d;
  logic [31:0]     pend_ext;
  logic [4:0]      lowest;
  kda_state_e      state_q, state_d;

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Free-running sample divider shared by all channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    kda_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef KDA_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .key_i       (key_in[g]),
      .level_o     (key_level[g]),
      .press_o     (press_pulse[g]),
      .release_o   (release_pulse[g]),
      .press_evt_o (press_evt[g]),
      .repeat_evt_o(repeat_evt[g])
    );
  end

`ifndef KDA_AUTO_REPEAT_EN
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY != REPEAT_RATE);
`endif

  // Pending bits are set at the same edge as the press pulse so the event is
  // presented one clk after it.
  assign set_vec  = press_evt | repeat_evt;
  assign pend_ext = 32'(pending_q);
  assign lowest   = kda_lowest_set(pend_ext);

  // Presentation FSM next state, pending update and overrun detection.
  always_comb begin
    state_d    = state_q;
    key_code_d = key_code_q;
    clr_vec    = '0;
    case (state_q)
      KDA_IDLE: begin
        if (|pending_q) begin
          state_d    = KDA_VALID;
          key_code_d = lowest[KCW-1:0];
          for (int i = 0; i < N_CH; i++) clr_vec[i] = (lowest == 5'(i));
        end
      end
      KDA_VALID: begin
        if (ack) state_d = KDA_IDLE;
      end
      default: state_d = KDA_IDLE;
    endcase
    pending_d = (pending_q & ~clr_vec) | set_vec;
    overrun_d = overrun_q | (|(set_vec & pending_q));
  end

  // Handshake and queue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= KDA_IDLE;
      key_code_q <= '0;
      pending_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_code_q <= key_code_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_valid = (state_q == KDA_VALID);
  assign key_code   = key_code_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_key_debounce_array.sv
module tb_key_debounce_array;

  localparam int N_CH = 4;
  localparam int TD   = 4;
  localparam int ST   = 3;
  localparam int SS   = 2;
  localparam int RD   = 2;
  localparam int RR   = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] key_in = '0;
  logic            ack = 1'b0;
  logic [N_CH-1:0] key_level, press_pulse, release_pulse;
  logic            data_valid, overrun;
  logic [1:0]      key_code;

  always #5 clk = ~clk;

  key_debounce_array #(
    .N_CH(N_CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .SYNC_STAGES(SS),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .data_valid(data_valid), .key_code(key_code), .ack(ack), .overrun(overrun)
  );

  int total = 0;
  int passed = 0;

  // reference model state (spec-level view)
  logic [N_CH-1:0] hist [SS];
  int              cyc;
  logic [N_CH-1:0] m_lvl, m_press, m_rel, m_pend;
  int              run [N_CH];
  int              held [N_CH];
  logic            m_valid, m_ovr;
  logic [1:0]      m_code;
  int              press_seen [N_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_idx(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SS; k++) hist[k] = '0;
    cyc = 0;
    m_lvl = '0; m_press = '0; m_rel = '0; m_pend = '0;
    m_valid = 1'b0; m_ovr = 1'b0; m_code = '0;
    for (int c = 0; c < N_CH; c++) begin run[c] = 0; held[c] = 0; end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    logic [N_CH-1:0] s, rep, set;
    bit tick;
    int idx;
    s = hist[SS-1];
    for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = key_in;
    tick = ((cyc % TD) == TD - 1);
    cyc++;
    m_press = '0; m_rel = '0; rep = '0;
    if (tick) begin
      for (int c = 0; c < N_CH; c++) begin
        if (s[c] != m_lvl[c]) begin
          run[c]++;
          if (run[c] == ST) begin
            run[c] = 0;
            m_lvl[c] = s[c];
            if (s[c]) begin m_press[c] = 1'b1; held[c] = 0; end
            else m_rel[c] = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
`ifdef KDA_AUTO_REPEAT_EN
        if (m_lvl[c] && !m_press[c]) begin
          held[c]++;
          if (held[c] == RD || (held[c] > RD && ((held[c] - RD) % RR) == 0)) rep[c] = 1'b1;
        end
`endif
      end
    end
    set = m_press | rep;
    if ((set & m_pend) != '0) m_ovr = 1'b1;
    if (!m_valid) begin
      if (m_pend != '0) begin
        idx = lowest_idx(m_pend);
        m_code = 2'(idx);
        m_valid = 1'b1;
        m_pend[idx] = 1'b0;
      end
    end else if (ack) begin
      m_valid = 1'b0;
    end
    m_pend = m_pend | set;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_update();
    #2;
    for (int c = 0; c < N_CH; c++) if (press_pulse[c]) press_seen[c]++;
    if (total - passed < 40) begin
      check("level",   32'(key_level),     32'(m_lvl));
      check("press",   32'(press_pulse),   32'(m_press));
      check("release", 32'(release_pulse), 32'(m_rel));
      check("valid",   32'(data_valid),    32'(m_valid));
      check("code",    32'(key_code),      32'(m_code));
      check("overrun", 32'(overrun),       32'(m_ovr));
    end
  endtask

  initial begin
    int lat, ev, first_code, second_code, gap, vcnt;
    int t_ev [3];
    bit found;
    logic prev_v;

    model_reset();
    for (int c = 0; c < N_CH; c++) press_seen[c] = 0;
    repeat (3) step();
    rst = 1'b0;

    // clean press on ch2
    key_in[2] = 1'b1;
    lat = 0; found = 0;
    while (!found && lat < 40) begin
      step(); lat++;
      if (key_level[2]) found = 1;
    end
    check("t1_level_rise", 32'(found), 32'd1);
    check("t1_latency", 32'(lat <= SS + ST * TD), 32'd1);
    check("t1_press_pulse", 32'(press_pulse[2]), 32'd1);
    step();
    check("t1_press_1clk", 32'(press_pulse[2]), 32'd0);
    check("t1_valid", 32'(data_valid), 32'd1);
    check("t1_code", 32'(key_code), 32'd2);
    for (int i = lat + 1; i < 40; i++) step();
    ack = 1'b1; repeat (3) step();
    key_in[2] = 1'b0; repeat (20) step();

    // bouncing ch1, then settled high
    press_seen[1] = 0;
    for (int i = 0; i < 10; i++) begin
      key_in[1] = (i % 2 == 0);
      repeat (3) step();
    end
    check("t2_no_pulse_bounce", 32'(press_seen[1]), 32'd0);
    check("t2_no_level_bounce", 32'(key_level[1]), 32'd0);
    key_in[1] = 1'b1;
    repeat (30) step();
    check("t2_one_pulse", 32'(press_seen[1]), 32'd1);
    check("t2_level_high", 32'(key_level[1]), 32'd1);
    key_in[1] = 1'b0; repeat (20) step();

    // ch0 and ch3 on the same tick, ack held
    key_in[0] = 1'b1; key_in[3] = 1'b1;
    ev = 0; gap = 0; first_code = -1; second_code = -1; prev_v = data_valid;
    for (int k = 0; k < 40 && ev < 2; k++) begin
      step();
      if (data_valid && !prev_v) begin
        if (ev == 0) first_code = int'(key_code);
        else second_code = int'(key_code);
        ev++;
      end else if (!data_valid && ev == 1) begin
        gap++;
      end
      prev_v = data_valid;
    end
    check("t3_two_events", 32'(ev), 32'd2);
    check("t3_first_code", 32'(first_code), 32'd0);
    check("t3_second_code", 32'(second_code), 32'd3);
    check("t3_idle_gap", 32'(gap), 32'd1);
    key_in[0] = 1'b0; key_in[3] = 1'b0; repeat (25) step();

    // ch1 press/release/press with no ack, then a third press
    ack = 1'b0;
    key_in[1] = 1'b1; repeat (20) step();
    check("t4_valid", 32'(data_valid), 32'd1);
    check("t4_code", 32'(key_code), 32'd1);
    key_in[1] = 1'b0; repeat (20) step();
    key_in[1] = 1'b1; repeat (20) step();
`ifndef KDA_AUTO_REPEAT_EN
    check("t4_no_overrun", 32'(overrun), 32'd0);
`endif
    key_in[1] = 1'b0; repeat (20) step();
    key_in[1] = 1'b1; repeat (20) step();
    check("t4_overrun", 32'(overrun), 32'd1);
    ack = 1'b1; step(); step();
    check("t4_requeued_valid", 32'(data_valid), 32'd1);
    check("t4_requeued_code", 32'(key_code), 32'd1);
    key_in[1] = 1'b0; repeat (20) step();

    // async reset with an event presented and another pending
    ack = 1'b0;
    key_in[0] = 1'b1; key_in[1] = 1'b1; repeat (20) step();
    check("t5_valid_before", 32'(data_valid), 32'd1);
    #1 rst = 1'b1;
    model_reset();
    key_in = '0;
    #1;
    check("t5_async_valid", 32'(data_valid), 32'd0);
    check("t5_async_level", 32'(key_level), 32'd0);
    check("t5_async_overrun", 32'(overrun), 32'd0);
    check("t5_async_code", 32'(key_code), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    ack = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (data_valid) vcnt++;
    end
    check("t5_no_event_after_rst", 32'(vcnt), 32'd0);

`ifdef KDA_AUTO_REPEAT_EN
    // auto-repeat timing on ch0, ack tied high
    key_in[0] = 1'b1;
    ev = 0; prev_v = data_valid;
    for (int k = 0; k < 60; k++) begin
      step();
      if (data_valid && !prev_v && ev < 3) begin t_ev[ev] = k; ev++; end
      prev_v = data_valid;
    end
    check("t6_events", 32'(ev), 32'd3);
    check("t6_first_repeat", 32'(t_ev[1] - t_ev[0]), 32'd8);
    check("t6_rate", 32'(t_ev[2] - t_ev[1]), 32'd4);
    key_in[0] = 1'b0; repeat (20) step();
`else
    t_ev[0] = 0;
`endif

    // randomized keys and ack against the model
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 11) == 0) key_in[c] = ~key_in[c];
      ack = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
